// File: rtl/io_clk_pkg.sv
// Shared types and sizing helpers for the I/O clock/reset sequencer.
package io_clk_pkg;

    typedef enum logic [1:0] {
        WAIT_LOCK,
        HOLD,
        RELEASE,
        RUN
    } clk_seq_state_e;

    // Bits needed to count from 0 up to max_val inclusive; never less than 1.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/clk_enable_div.sv
// One clock-enable channel: shadow divide ratio, wrap counter, ce pulse and tick square wave.
module clk_enable_div #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             chan_rst,
    input  logic             chan_rst_nxt,
    input  logic [CNT_W-1:0] div,
    output logic             ce,
    output logic             tick
);

    logic [CNT_W-1:0] shadow;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] last;

    always_comb begin
        last = '0;
        if (shadow != '0)
            last = shadow - CNT_W'(1);
    end

    // Shadow tracks div while the channel is held, so it freezes on the edge reset falls.
    // Clearing on chan_rst_nxt as well lets ce/tick drop on the same edge rst_out rises.
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow <= '0;
            cnt    <= '0;
            ce     <= 1'b0;
            tick   <= 1'b0;
        end else begin
            if (chan_rst)
                shadow <= div;
            if (chan_rst || chan_rst_nxt) begin
                cnt  <= '0;
                ce   <= 1'b0;
                tick <= 1'b0;
            end else if (cnt == last) begin
                cnt  <= '0;
                ce   <= 1'b1;
                tick <= ~tick;
            end else begin
                cnt  <= cnt + CNT_W'(1);
                ce   <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/io_clock_sequencer.sv
// MMCM lock qualification, staggered per-domain reset release and per-domain clock enables.
module io_clock_sequencer
    import io_clk_pkg::*;
#(
    parameter int unsigned NUM_CH      = 3,
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned HOLD_CYCLES = 1024,
    parameter int unsigned STAGGER     = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    locked,
    input  logic [NUM_CH*CNT_W-1:0] div,
    output logic [NUM_CH-1:0]       ce,
    output logic [NUM_CH-1:0]       tick,
    output logic [NUM_CH-1:0]       rst_out,
    output logic                    ready,
    output logic                    lock_lost
);

    localparam int unsigned HOLD_W   = cnt_width(HOLD_CYCLES - 1);
    localparam int unsigned LAST_POS = (NUM_CH - 1) * STAGGER;
    localparam int unsigned STG_W    = cnt_width(LAST_POS);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

    logic               lk_m;
    logic               lk_s;
    clk_seq_state_e     state;
    clk_seq_state_e     state_nxt;
    logic [HOLD_W-1:0]  hold_cnt;
    logic [HOLD_W-1:0]  hold_nxt;
    logic [STG_W-1:0]   stg_cnt;
    logic [STG_W-1:0]   stg_nxt;
    logic [NUM_CH-1:0]  rst_nxt;
    logic               lost_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            lk_m      <= 1'b0;
            lk_s      <= 1'b0;
            state     <= WAIT_LOCK;
            hold_cnt  <= '0;
            stg_cnt   <= '0;
            rst_out   <= '1;
            ready     <= 1'b0;
            lock_lost <= 1'b0;
        end else begin
            lk_m      <= locked;
            lk_s      <= lk_m;
            state     <= state_nxt;
            hold_cnt  <= hold_nxt;
            stg_cnt   <= stg_nxt;
            rst_out   <= rst_nxt;
            ready     <= (state_nxt == RUN);
            lock_lost <= lost_nxt;
        end
    end

    // stg_nxt is the stagger position after the coming edge; channel k leaves
    // reset once that position reaches k*STAGGER, so rst_out stays registered.
    always_comb begin
        state_nxt = state;
        hold_nxt  = hold_cnt;
        stg_nxt   = stg_cnt;
        rst_nxt   = rst_out;
        lost_nxt  = lock_lost;
        unique case (state)
            WAIT_LOCK: begin
                rst_nxt  = '1;
                hold_nxt = '0;
                stg_nxt  = '0;
                if (lk_s)
                    state_nxt = HOLD;
            end
            HOLD: begin
                if (!lk_s) begin
                    state_nxt = WAIT_LOCK;
                    hold_nxt  = '0;
                end else if (hold_cnt == HOLD_LAST) begin
                    stg_nxt    = '0;
                    rst_nxt    = '1;
                    rst_nxt[0] = 1'b0;
                    state_nxt  = (LAST_POS == 0) ? RUN : RELEASE;
                end else begin
                    hold_nxt = hold_cnt + HOLD_W'(1);
                end
            end
            RELEASE: begin
                if (!lk_s) begin
                    state_nxt = WAIT_LOCK;
                    rst_nxt   = '1;
                    stg_nxt   = '0;
                    lost_nxt  = 1'b1;
                end else begin
                    stg_nxt = stg_cnt + STG_W'(1);
                    for (int unsigned k = 0; k < NUM_CH; k++)
                        rst_nxt[k] = (32'(stg_nxt) < k * STAGGER);
                    if (32'(stg_nxt) >= LAST_POS)
                        state_nxt = RUN;
                end
            end
            RUN: begin
                rst_nxt = '0;
                if (!lk_s) begin
                    state_nxt = WAIT_LOCK;
                    rst_nxt   = '1;
                    lost_nxt  = 1'b1;
                end
            end
            default: begin
                state_nxt = WAIT_LOCK;
                rst_nxt   = '1;
            end
        endcase
    end

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        clk_enable_div #(
            .CNT_W(CNT_W)
        ) u_div (
            .clk          (clk),
            .rst          (rst),
            .chan_rst     (rst_out[k]),
            .chan_rst_nxt (rst_nxt[k]),
            .div          (div[k*CNT_W +: CNT_W]),
            .ce           (ce[k]),
            .tick         (tick[k])
        );
    end

endmodule

// File: tb/tb_io_clock_sequencer.sv
// Directed bench for io_clock_sequencer: 3 channels, hold 16, stagger 4, div {5,3,1}.
module tb_io_clock_sequencer;

    localparam int unsigned NUM_CH      = 3;
    localparam int unsigned CNT_W       = 16;
    localparam int unsigned HOLD_CYCLES = 16;
    localparam int unsigned STAGGER     = 4;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    locked;
    logic [NUM_CH*CNT_W-1:0] div;
    logic [NUM_CH-1:0]       ce;
    logic [NUM_CH-1:0]       tick;
    logic [NUM_CH-1:0]       rst_out;
    logic                    ready;
    logic                    lock_lost;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    io_clock_sequencer #(
        .NUM_CH      (NUM_CH),
        .CNT_W       (CNT_W),
        .HOLD_CYCLES (HOLD_CYCLES),
        .STAGGER     (STAGGER)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .locked    (locked),
        .div       (div),
        .ce        (ce),
        .tick      (tick),
        .rst_out   (rst_out),
        .ready     (ready),
        .lock_lost (lock_lost)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // j = edges after E (first edge sampling locked=1); r0 = edge where ch0 is released.
    function automatic logic [2:0] exp_rst(input int j, input int r0);
        logic [2:0] e;
        for (int k = 0; k < 3; k++)
            e[k] = (j < r0 + k * 4);
        return e;
    endfunction

    function automatic logic [2:0] exp_ce(input int j, input int r0, input int d1);
        logic [2:0] e;
        int d[3];
        int rel;
        d[0] = 1; d[1] = d1; d[2] = 5;
        for (int k = 0; k < 3; k++) begin
            rel  = r0 + k * 4;
            e[k] = (j > rel) && (((j - rel) % d[k]) == 0);
        end
        return e;
    endfunction

    function automatic logic [2:0] exp_tick(input int j, input int r0, input int d1);
        logic [2:0] e;
        int d[3];
        int rel;
        d[0] = 1; d[1] = d1; d[2] = 5;
        for (int k = 0; k < 3; k++) begin
            rel  = r0 + k * 4;
            e[k] = (j > rel) ? ((((j - rel) / d[k]) % 2) == 1) : 1'b0;
        end
        return e;
    endfunction

    task automatic test_reset();
        rst    = 1'b1;
        locked = 1'b0;
        div    = {16'd5, 16'd3, 16'd1};
        step();
        step();
        total++; if (rst_out !== 3'b111) begin bad++; $display("FAIL reset_rst_out got=%b exp=111", rst_out); end
        total++; if (ce !== 3'b000) begin bad++; $display("FAIL reset_ce got=%b exp=000", ce); end
        total++; if (tick !== 3'b000) begin bad++; $display("FAIL reset_tick got=%b exp=000", tick); end
        total++; if (ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b exp=0", ready); end
        total++; if (lock_lost !== 1'b0) begin bad++; $display("FAIL reset_lock_lost got=%b exp=0", lock_lost); end
        rst = 1'b0;
        repeat (3) step();
        total++; if (rst_out !== 3'b111) begin bad++; $display("FAIL nolock_rst_out got=%b exp=111", rst_out); end
        total++; if (ready !== 1'b0) begin bad++; $display("FAIL nolock_ready got=%b exp=0", ready); end
    endtask

    task automatic test_clean_lock();
        locked = 1'b1;
        for (int j = 0; j <= 45; j++) begin
            step();
            total++; if (rst_out !== exp_rst(j, 18)) begin bad++; $display("FAIL clean_rst_out j=%0d got=%b exp=%b", j, rst_out, exp_rst(j, 18)); end
            total++; if (ready !== (j >= 26)) begin bad++; $display("FAIL clean_ready j=%0d got=%b exp=%b", j, ready, (j >= 26)); end
            total++; if (ce !== exp_ce(j, 18, 3)) begin bad++; $display("FAIL clean_ce j=%0d got=%b exp=%b", j, ce, exp_ce(j, 18, 3)); end
            total++; if (tick !== exp_tick(j, 18, 3)) begin bad++; $display("FAIL clean_tick j=%0d got=%b exp=%b", j, tick, exp_tick(j, 18, 3)); end
            total++; if (lock_lost !== 1'b0) begin bad++; $display("FAIL clean_lock_lost j=%0d got=%b exp=0", j, lock_lost); end
        end
    endtask

    task automatic test_div_change();
        bit found = 1'b0;
        div[31:16] = 16'd7;
        for (int i = 0; i < 6; i++) begin
            step();
            if (ce[1]) begin
                found = 1'b1;
                break;
            end
        end
        total++; if (!found) begin bad++; $display("FAIL divchg_first_ce got=none exp=pulse within 6 cycles"); end
        if (found) begin
            for (int i = 1; i <= 9; i++) begin
                step();
                total++; if (ce[1] !== ((i % 3) == 0)) begin bad++; $display("FAIL divchg_ce1 i=%0d got=%b exp=%b", i, ce[1], ((i % 3) == 0)); end
            end
        end
    endtask

    task automatic test_lock_loss();
        locked = 1'b0;
        for (int j = 0; j <= 6; j++) begin
            step();
            total++; if (rst_out !== ((j >= 2) ? 3'b111 : 3'b000)) begin bad++; $display("FAIL loss_rst_out j=%0d got=%b exp=%b", j, rst_out, ((j >= 2) ? 3'b111 : 3'b000)); end
            total++; if (ready !== (j < 2)) begin bad++; $display("FAIL loss_ready j=%0d got=%b exp=%b", j, ready, (j < 2)); end
            if (j >= 2) begin
                total++; if (ce !== 3'b000) begin bad++; $display("FAIL loss_ce j=%0d got=%b exp=000", j, ce); end
                total++; if (tick !== 3'b000) begin bad++; $display("FAIL loss_tick j=%0d got=%b exp=000", j, tick); end
                total++; if (lock_lost !== 1'b1) begin bad++; $display("FAIL loss_lock_lost j=%0d got=%b exp=1", j, lock_lost); end
            end
        end
    endtask

    task automatic test_relock();
        locked = 1'b1;
        for (int j = 0; j <= 45; j++) begin
            step();
            total++; if (rst_out !== exp_rst(j, 18)) begin bad++; $display("FAIL relock_rst_out j=%0d got=%b exp=%b", j, rst_out, exp_rst(j, 18)); end
            total++; if (ready !== (j >= 26)) begin bad++; $display("FAIL relock_ready j=%0d got=%b exp=%b", j, ready, (j >= 26)); end
            total++; if (ce !== exp_ce(j, 18, 7)) begin bad++; $display("FAIL relock_ce j=%0d got=%b exp=%b", j, ce, exp_ce(j, 18, 7)); end
            total++; if (tick !== exp_tick(j, 18, 7)) begin bad++; $display("FAIL relock_tick j=%0d got=%b exp=%b", j, tick, exp_tick(j, 18, 7)); end
            total++; if (lock_lost !== 1'b1) begin bad++; $display("FAIL relock_lock_lost j=%0d got=%b exp=1", j, lock_lost); end
        end
    endtask

    task automatic test_rst_release();
        locked = 1'b0;
        repeat (5) step();
        locked = 1'b1;
        for (int j = 0; j <= 19; j++) begin
            step();
            if (j == 17) begin
                total++; if (rst_out !== 3'b111) begin bad++; $display("FAIL rstrel_pre_rst_out got=%b exp=111", rst_out); end
            end
            if (j == 19) begin
                total++; if (rst_out !== 3'b110) begin bad++; $display("FAIL rstrel_mid_rst_out got=%b exp=110", rst_out); end
                total++; if (ce[0] !== 1'b1) begin bad++; $display("FAIL rstrel_mid_ce0 got=%b exp=1", ce[0]); end
                total++; if (lock_lost !== 1'b1) begin bad++; $display("FAIL rstrel_mid_lock_lost got=%b exp=1", lock_lost); end
            end
        end
        rst = 1'b1;
        step();
        total++; if (rst_out !== 3'b111) begin bad++; $display("FAIL rstrel_rst_out got=%b exp=111", rst_out); end
        total++; if (ce !== 3'b000) begin bad++; $display("FAIL rstrel_ce got=%b exp=000", ce); end
        total++; if (tick !== 3'b000) begin bad++; $display("FAIL rstrel_tick got=%b exp=000", tick); end
        total++; if (ready !== 1'b0) begin bad++; $display("FAIL rstrel_ready got=%b exp=0", ready); end
        total++; if (lock_lost !== 1'b0) begin bad++; $display("FAIL rstrel_lock_lost got=%b exp=0", lock_lost); end
        rst = 1'b0;
        for (int j = 0; j <= 18; j++) begin
            step();
            if (j == 17) begin
                total++; if (rst_out !== 3'b111) begin bad++; $display("FAIL rstrel_restart_hold got=%b exp=111", rst_out); end
            end
            if (j == 18) begin
                total++; if (rst_out !== 3'b110) begin bad++; $display("FAIL rstrel_restart_rel got=%b exp=110", rst_out); end
                total++; if (lock_lost !== 1'b0) begin bad++; $display("FAIL rstrel_restart_lock_lost got=%b exp=0", lock_lost); end
            end
        end
    endtask

    task automatic test_lock_glitch();
        locked = 1'b0;
        rst    = 1'b1;
        step();
        rst = 1'b0;
        step();
        step();
        locked = 1'b1;
        for (int j = 0; j <= 40; j++) begin
            step();
            total++; if (rst_out !== exp_rst(j, 29)) begin bad++; $display("FAIL glitch_rst_out j=%0d got=%b exp=%b", j, rst_out, exp_rst(j, 29)); end
            total++; if (ready !== (j >= 37)) begin bad++; $display("FAIL glitch_ready j=%0d got=%b exp=%b", j, ready, (j >= 37)); end
            total++; if (lock_lost !== 1'b0) begin bad++; $display("FAIL glitch_lock_lost j=%0d got=%b exp=0", j, lock_lost); end
            if (j == 9)
                locked = 1'b0;
            if (j == 10)
                locked = 1'b1;
        end
    endtask

    initial begin
        rst    = 1'b1;
        locked = 1'b0;
        div    = '0;
        test_reset();
        test_clean_lock();
        test_div_change();
        test_lock_loss();
        test_relock();
        test_rst_release();
        test_lock_glitch();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
